// File: rtl/chacha_bus_master_if.sv
// Host job/stream handshakes and the core register-bus signals of chacha_bus_master,
// bundled so the sequencer and its environment connect through one port.
interface chacha_bus_master_if;
    // Streams: a word moves on any rising edge where valid and ready are both 1.
    // The source holds valid and data stable until that edge, and ready may depend on state only.
    logic        start;
    logic [7:0]  num_blocks;
    logic        busy;
    logic        done;
    logic        error;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (
        input  start, num_blocks, in_valid, in_data, out_ready, read_data,
        output busy, done, error, in_ready, out_valid, out_data, cs, we, address, write_data
    );

    modport slave (
        output start, num_blocks, in_valid, in_data, out_ready, read_data,
        input  busy, done, error, in_ready, out_valid, out_data, cs, we, address, write_data
    );
endinterface

// File: rtl/chacha_bus_master.sv
// Sequencer that programs the chacha20_poly1305_bus register map from a word stream
// and returns 16 result words per block on an output stream.
module chacha_bus_master #(
    parameter int POLL_LIMIT = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    chacha_bus_master_if.master        bus_if,
    output logic [3:0]                 dbg_state_o
);
    typedef enum logic [3:0] {
        IDLE, KEY, NONCE, INIT, POLL_I, DATA, NEXT, POLL_N, READ, FIN
    } state_t;

    localparam int PW = $clog2(POLL_LIMIT) + 1;
    localparam logic [7:0] ADDR_CTRL   = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h09;
    localparam logic [7:0] ADDR_KEY    = 8'h10;
    localparam logic [7:0] ADDR_NONCE  = 8'h20;
    localparam logic [7:0] ADDR_DIN    = 8'h30;
    localparam logic [7:0] ADDR_RES    = 8'h40;

    state_t        state_q, state_d;
    logic [7:0]    blocks_q, blocks_d;
    logic [3:0]    widx_q, widx_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          cs_q, cs_d, we_q, we_d;
    logic [7:0]    addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          error_q, error_d;
    logic          in_hs, status_rd, rd_commit;

    assign bus_if.in_ready = (state_q == KEY) || (state_q == NONCE) || (state_q == DATA);
    assign in_hs     = bus_if.in_valid && bus_if.in_ready;
    assign status_rd = cs_q && !we_q;
    // A result read launched on a prediction of out_ready is simply retried if the slot is still full.
    assign rd_commit = (state_q == READ) && cs_q && !we_q && (!out_valid_q || bus_if.out_ready);

    always_comb begin
        state_d     = state_q;
        blocks_d    = blocks_q;
        widx_d      = widx_q;
        pcnt_d      = pcnt_q;
        cs_d        = 1'b0;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        out_valid_d = out_valid_q && !bus_if.out_ready;
        out_data_d  = out_data_q;
        error_d     = 1'b0;

        case (state_q)
            IDLE: if (bus_if.start) begin
                state_d  = KEY;
                blocks_d = bus_if.num_blocks;
                widx_d   = 4'd0;
            end
            KEY, NONCE, DATA: if (in_hs) begin
                cs_d    = 1'b1;
                we_d    = 1'b1;
                wdata_d = bus_if.in_data;
                widx_d  = widx_q + 4'd1;
                if (state_q == KEY) begin
                    addr_d = ADDR_KEY + {4'h0, widx_q};
                    if (widx_q == 4'd7) begin
                        state_d = NONCE;
                        widx_d  = 4'd0;
                    end
                end else if (state_q == NONCE) begin
                    addr_d = ADDR_NONCE + {4'h0, widx_q};
                    if (widx_q == 4'd2) begin
                        state_d = INIT;
                        widx_d  = 4'd0;
                    end
                end else begin
                    addr_d = ADDR_DIN + {4'h0, widx_q};
                    if (widx_q == 4'd15) begin
                        state_d = NEXT;
                        widx_d  = 4'd0;
                    end
                end
            end
            INIT, NEXT: begin
                cs_d    = 1'b1;
                we_d    = 1'b1;
                addr_d  = ADDR_CTRL;
                wdata_d = (state_q == INIT) ? 32'h1 : 32'h2;
                state_d = (state_q == INIT) ? POLL_I : POLL_N;
                pcnt_d  = '0;
            end
            POLL_I, POLL_N: begin
                cs_d   = 1'b1;
                addr_d = ADDR_STATUS;
                if (status_rd) begin
                    if (bus_if.read_data[0]) begin
                        cs_d   = 1'b0;
                        widx_d = 4'd0;
                        if (state_q == POLL_N) state_d = READ;
                        else if (blocks_q == 8'd0) state_d = FIN;
                        else state_d = DATA;
                    end else if (pcnt_q == PW'(POLL_LIMIT - 1)) begin
                        cs_d    = 1'b0;
                        error_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        pcnt_d = pcnt_q + PW'(1);
                    end
                end
            end
            READ: if (rd_commit) begin
                out_valid_d = 1'b1;
                out_data_d  = bus_if.read_data;
                widx_d      = widx_q + 4'd1;
                if (widx_q == 4'd15) begin
                    blocks_d = blocks_q - 8'd1;
                    state_d  = (blocks_q == 8'd1) ? FIN : DATA;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Result reads keep one word per cycle flowing while the consumer is taking words.
        if (state_d == READ && (!out_valid_d || bus_if.out_ready)) begin
            cs_d   = 1'b1;
            we_d   = 1'b0;
            addr_d = ADDR_RES + {4'h0, widx_d};
        end
        if (state_d == FIN && state_q != FIN) begin
            cs_d    = 1'b1;
            we_d    = 1'b1;
            addr_d  = ADDR_CTRL;
            wdata_d = 32'h4;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            blocks_q    <= 8'd0;
            widx_q      <= 4'd0;
            pcnt_q      <= '0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 8'd0;
            wdata_q     <= 32'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            blocks_q    <= blocks_d;
            widx_q      <= widx_d;
            pcnt_q      <= pcnt_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            error_q     <= error_d;
        end
    end

    assign bus_if.busy       = (state_q != IDLE);
    assign bus_if.done       = (state_q == FIN);
    assign bus_if.error      = error_q;
    assign bus_if.out_valid  = out_valid_q;
    assign bus_if.out_data   = out_data_q;
    assign bus_if.cs         = cs_q;
    assign bus_if.we         = we_q;
    assign bus_if.address    = addr_q;
    assign bus_if.write_data = wdata_q;
    assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_chacha_bus_master.sv
// Directed bench for chacha_bus_master: job table plus reset, busy-start and done-cycle corner cases,
// against a small register-core model with programmable status latency.
module tb_chacha_bus_master;
    logic       clk;
    logic       reset_n;
    logic [3:0] dbg_state;

    chacha_bus_master_if bus_if();

    chacha_bus_master #(.POLL_LIMIT(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus_if      (bus_if),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int nb;
        int lat;
        bit stuck;
        bit toggle;
        bit poke;
        bit start_at_done;
        int exp_done;
        int exp_err;
        int exp_nout;
        int exp_nstat;
        int exp_nwr;
    } vec_t;

    int n_cmp;
    int n_fail;

    // core model
    int         cur_lat;
    logic       m_stuck;
    logic [7:0] m_wait;
    logic [7:0] m_nexts;
    logic [7:0] m_blk;
    assign m_blk = m_nexts - 8'd1;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_wait  <= 8'd0;
            m_nexts <= 8'd0;
        end else if (bus_if.cs) begin
            if (bus_if.we && bus_if.address == 8'h08 && bus_if.write_data == 32'h1) begin
                m_wait  <= 8'(cur_lat);
                m_nexts <= 8'd0;
            end else if (bus_if.we && bus_if.address == 8'h08 && bus_if.write_data == 32'h2) begin
                m_wait  <= 8'(cur_lat);
                m_nexts <= m_nexts + 8'd1;
            end else if (!bus_if.we && bus_if.address == 8'h09 && m_wait != 8'd0) begin
                m_wait <= m_wait - 8'd1;
            end
        end
    end

    assign bus_if.read_data = !(bus_if.cs && !bus_if.we) ? 32'h0 :
                              (bus_if.address == 8'h09) ? {31'h0, (!m_stuck && m_wait == 8'd0)} :
                              (bus_if.address[7:4] == 4'h4) ? {8'hA0, 8'h00, m_blk, 4'h0, bus_if.address[3:0]} :
                              32'h0;

    // monitor
    logic [39:0] wr_log[$];
    logic [31:0] out_log[$];
    logic [39:0] exp_q[$];
    int nstat, ndone, nerr;

    always @(negedge clk) begin
        if (bus_if.cs) begin
            if (bus_if.we) wr_log.push_back({bus_if.address, bus_if.write_data});
            else if (bus_if.address == 8'h09) nstat++;
        end
        if (bus_if.out_valid && bus_if.out_ready) out_log.push_back(bus_if.out_data);
        if (bus_if.done) ndone++;
        if (bus_if.error) nerr++;
    end

    bit toggle_mode;
    initial begin
        bus_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 bus_if.out_ready = toggle_mode ? ~bus_if.out_ready : 1'b1;
        end
    end

    logic [31:0] key_w[8];
    logic [31:0] nonce_w[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [7:0] nb);
        @(posedge clk);
        #1;
        bus_if.start      = 1'b1;
        bus_if.num_blocks = nb;
        @(posedge clk);
        #1;
        bus_if.start      = 1'b0;
        bus_if.num_blocks = 8'hFF;
    endtask

    task automatic send_word(input logic [31:0] w, input string name);
        bit ok;
        ok = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = w;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus_if.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 bus_if.in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: in_ready timeout got 0 expected 1", name);
        end
    endtask

    task automatic run_job(input vec_t v, input string tag);
        bit finished;
        int n_ctrl4;
        wr_log.delete();
        out_log.delete();
        exp_q.delete();
        nstat = 0;
        ndone = 0;
        nerr  = 0;
        cur_lat     = v.lat;
        m_stuck     = v.stuck;
        toggle_mode = v.toggle;

        for (int i = 0; i < 8; i++) exp_q.push_back({8'h10 + 8'(i), key_w[i]});
        for (int i = 0; i < 3; i++) exp_q.push_back({8'h20 + 8'(i), nonce_w[i]});
        exp_q.push_back({8'h08, 32'h1});
        if (!v.stuck) begin
            for (int b = 0; b < v.nb; b++) begin
                for (int i = 0; i < 16; i++) exp_q.push_back({8'h30 + 8'(i), 32'hD000_0000 + 32'(b * 256 + i)});
                exp_q.push_back({8'h08, 32'h2});
            end
            exp_q.push_back({8'h08, 32'h4});
        end

        pulse_start(8'(v.nb));
        for (int i = 0; i < 11; i++) begin
            send_word((i < 8) ? key_w[i] : nonce_w[i - 8], $sformatf("%s_kn%0d", tag, i));
            if (v.poke && i == 3) pulse_start(8'd5);
        end
        if (!v.stuck) begin
            for (int b = 0; b < v.nb; b++)
                for (int i = 0; i < 16; i++)
                    send_word(32'hD000_0000 + 32'(b * 256 + i), $sformatf("%s_d%0d_%0d", tag, b, i));
        end

        finished = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(posedge clk);
            #1;
            if (bus_if.done || bus_if.error) begin
                finished = 1'b1;
                if (v.start_at_done && bus_if.done) begin
                    bus_if.start      = 1'b1;
                    bus_if.num_blocks = 8'd0;
                    @(posedge clk);
                    #1 bus_if.start = 1'b0;
                end
                break;
            end
        end
        check({tag, "_finished"}, 64'(finished), 64'd1);

        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (!bus_if.out_valid) break;
        end
        repeat (3) @(posedge clk);
        #1;

        check({tag, "_done_pulses"}, 64'(ndone), 64'(v.exp_done));
        check({tag, "_error_pulses"}, 64'(nerr), 64'(v.exp_err));
        check({tag, "_busy_after"}, 64'(bus_if.busy), 64'd0);
        check({tag, "_status_reads"}, 64'(nstat), 64'(v.exp_nstat));
        check({tag, "_out_count"}, 64'(out_log.size()), 64'(v.exp_nout));
        for (int k = 0; k < out_log.size() && k < v.exp_nout; k++)
            check($sformatf("%s_out%0d", tag, k), 64'(out_log[k]), 64'(32'hA000_0000 + 32'((k / 16) * 256 + (k % 16))));
        check({tag, "_wr_count"}, 64'(wr_log.size()), 64'(v.exp_nwr));
        for (int k = 0; k < wr_log.size() && k < exp_q.size(); k++)
            check($sformatf("%s_wr%0d", tag, k), 64'(wr_log[k]), 64'(exp_q[k]));
        n_ctrl4 = 0;
        foreach (wr_log[k]) if (wr_log[k] == {8'h08, 32'h4}) n_ctrl4++;
        check({tag, "_ctrl4_writes"}, 64'(n_ctrl4), 64'(v.exp_done));
    endtask

    vec_t vecs[6];
    vec_t replay;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        key_w   = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff,
                    32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'hfeedface};
        nonce_w = '{32'h01010101, 32'h02020202, 32'h03030303};
        //          nb lat stk tog poke sad done err nout nstat nwr
        vecs[0] = '{0, 3, 0, 0, 0, 1, 1, 0, 0,  4,  13};
        vecs[1] = '{1, 2, 0, 0, 0, 0, 1, 0, 16, 6,  30};
        vecs[2] = '{2, 1, 0, 1, 0, 0, 1, 0, 32, 6,  47};
        vecs[3] = '{1, 0, 1, 0, 0, 0, 0, 1, 0,  8,  12};
        vecs[4] = '{0, 0, 0, 0, 1, 0, 1, 0, 0,  1,  13};
        vecs[5] = '{3, 7, 0, 1, 1, 0, 1, 0, 48, 32, 64};
        replay  = '{1, 1, 0, 0, 0, 0, 1, 0, 16, 4,  30};

        cur_lat           = 0;
        m_stuck           = 1'b0;
        toggle_mode       = 1'b0;
        bus_if.start      = 1'b0;
        bus_if.num_blocks = 8'd0;
        bus_if.in_valid   = 1'b0;
        bus_if.in_data    = 32'd0;
        reset_n           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus_if.busy), 64'd0);
        check("rst_done", 64'(bus_if.done), 64'd0);
        check("rst_error", 64'(bus_if.error), 64'd0);
        check("rst_in_ready", 64'(bus_if.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        check("rst_bus", 64'({bus_if.cs, bus_if.we, bus_if.address}), 64'd0);
        check("rst_wdata_odata", 64'({bus_if.write_data, bus_if.out_data}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        reset_n = 1'b1;

        for (int r = 0; r < 6; r++) run_job(vecs[r], $sformatf("v%0d", r));

        // reset while data word 5 is on offer
        cur_lat     = 1;
        m_stuck     = 1'b0;
        toggle_mode = 1'b0;
        pulse_start(8'd1);
        for (int i = 0; i < 11; i++) send_word((i < 8) ? key_w[i] : nonce_w[i - 8], $sformatf("rs_kn%0d", i));
        for (int i = 0; i < 5; i++) send_word(32'hD000_0000 + 32'(i), $sformatf("rs_d%0d", i));
        check("rs_state_data", 64'(dbg_state), 64'd5);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 32'hD000_0005;
        reset_n         = 1'b0;
        @(posedge clk);
        #1;
        check("rs_busy", 64'(bus_if.busy), 64'd0);
        check("rs_in_ready", 64'(bus_if.in_ready), 64'd0);
        check("rs_bus", 64'({bus_if.cs, bus_if.we, bus_if.address, bus_if.write_data}), 64'd0);
        check("rs_out", 64'({bus_if.out_valid, bus_if.out_data}), 64'd0);
        check("rs_state", 64'(dbg_state), 64'd0);
        bus_if.in_valid = 1'b0;
        reset_n         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rs_first_cycle_idle", 64'(bus_if.cs), 64'd0);
        run_job(replay, "replay");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
